oaat_hash_pipe: RTL

OAAT_HASH_PIPE -- requirements
Module: oaat_hash_pipe

---
 rtl/oaat_hash_pkg.sv | 28 ++
 rtl/oaat_mix_round.sv | 17 +
 rtl/oaat_hash_pipe.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/oaat_hash_pkg.sv
// Shared types, constants and index helpers for the one-at-a-time hash pipeline.
package oaat_hash_pkg;

   typedef logic [31:0] hash_t;

   localparam int KEY_BYTES_MAX = 16;

   // Per-byte mix shifts
   localparam int SH_M1 = 9;
   localparam int SH_M2 = 4;

   // Finalise shifts
   localparam int SH_F1 = 5;
   localparam int SH_F2 = 9;
   localparam int SH_F3 = 13;

   // Stage k of a kb-byte pipe still carries kb-1-k unconsumed bytes. All stages share
   // one flat byte vector, stage 0 first. This returns where stage k's bytes start.
   function automatic int tri_off(input int kb, input int k);
      return k * (kb - 1) - (k * (k - 1)) / 2;
   endfunction

   // Total number of unconsumed-key bytes held across all mix stages.
   function automatic int tri_bytes(input int kb);
      return (kb * (kb - 1)) / 2;
   endfunction

endpackage

// File: rtl/oaat_mix_round.sv
// One combinational mix round: add a key byte, then shift-add and shift-xor.
module oaat_mix_round
   import oaat_hash_pkg::*;
(
   input  hash_t      prev_i,
   input  logic [7:0] byte_i,
   output hash_t      hash_o
);

   hash_t h_add;
   hash_t h_sh;

   assign h_add  = prev_i + {24'd0, byte_i};
   assign h_sh   = h_add + (h_add << SH_M1);
   assign hash_o = h_sh ^ (h_sh >> SH_M2);

endmodule

// File: rtl/oaat_hash_pipe.sv
// Fully pipelined one-at-a-time hash: one mix stage per key byte, then a finalise
// stage. The whole pipe moves as one, so back-pressure from out_ready stalls every stage.
module oaat_hash_pipe
   import oaat_hash_pkg::*;
#(
   parameter int KEY_BYTES = 6,
   parameter int IDX_W     = 10,
   parameter int TAG_W     = 8
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*KEY_BYTES-1:0] in_key,
   input  logic [31:0]            in_seed,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_hash,
   output logic [IDX_W-1:0]       out_idx,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   busy
);

   localparam int NSTG = KEY_BYTES + 1;
   localparam int FIN  = KEY_BYTES;

   logic                   advance;
   logic [NSTG-1:0]        valid_q, valid_d;
   hash_t                  hash_q [NSTG];
   hash_t                  hash_d [NSTG];
   logic [TAG_W-1:0]       tag_q  [NSTG];
   logic [TAG_W-1:0]       tag_d  [NSTG];
   logic [KEY_BYTES-1:0][7:0] mix_byte;
   hash_t                  mix_hash [KEY_BYTES];
   hash_t                  fin_a, fin_b, fin_c;

   assign out_valid = valid_q[FIN];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_hash  = hash_q[FIN];
   assign out_idx   = hash_q[FIN][IDX_W-1:0];
   assign out_tag   = tag_q[FIN];
   assign busy      = |valid_q;

   // Mix round k consumes key byte k; stage 0 starts from the seed.
   for (genvar k = 0; k < KEY_BYTES; k++) begin : g_mix
      hash_t prev;
      if (k == 0) begin : g_first
         assign prev = in_seed;
      end else begin : g_next
         assign prev = hash_q[k-1];
      end
      oaat_mix_round u_round (
         .prev_i (prev),
         .byte_i (mix_byte[k]),
         .hash_o (mix_hash[k])
      );
   end

   // Unconsumed key bytes ride along in a triangular store. Local byte b of every
   // stage is key byte KEY_BYTES-1-b, so each stage copies the low bytes of the one
   // before and drops that stage's top byte, which is the byte it has just mixed.
   if (KEY_BYTES > 1) begin : g_key
      localparam int TRI = tri_bytes(KEY_BYTES);

      logic [TRI-1:0][7:0]       key_q, key_d;
      logic [KEY_BYTES-1:1][7:0] later_byte;

      // Shift the remaining key bytes one stage down on advance.
      always_comb begin
         key_d = key_q;
         if (advance) begin
            for (int b = 0; b < KEY_BYTES - 1; b++) begin
               key_d[b] = in_key[8*b +: 8];
            end
            for (int k = 1; k < KEY_BYTES - 1; k++) begin
               for (int b = 0; b < KEY_BYTES - 1 - k; b++) begin
                  key_d[tri_off(KEY_BYTES, k) + b] = key_q[tri_off(KEY_BYTES, k - 1) + b];
               end
            end
         end
      end

      // Byte k for mix round k is the top byte still held by stage k-1.
      always_comb begin
         later_byte = '0;
         for (int k = 1; k < KEY_BYTES; k++) begin
            later_byte[k] = key_q[tri_off(KEY_BYTES, k - 1) + KEY_BYTES - 1 - k];
         end
      end

      // Key byte store register.
      always_ff @(posedge clk) begin
         if (reset) begin
            key_q <= '0;
         end else begin
            key_q <= key_d;
         end
      end

      assign mix_byte = {later_byte, in_key[8*KEY_BYTES-1 -: 8]};
   end else begin : g_nokey
      assign mix_byte = in_key;
   end

   // Finalise avalanche applied to the last mix result.
   always_comb begin
      fin_a = hash_q[FIN-1] + (hash_q[FIN-1] << SH_F1);
      fin_b = fin_a ^ (fin_a >> SH_F2);
      fin_c = fin_b + (fin_b << SH_F3);
   end

   // Next state of every stage: shift the pipe on advance, otherwise hold bubbles and all.
   always_comb begin
      valid_d = valid_q;
      for (int k = 0; k < NSTG; k++) begin
         hash_d[k] = hash_q[k];
         tag_d[k]  = tag_q[k];
      end
      if (advance) begin
         valid_d[0] = in_valid;
         hash_d[0]  = mix_hash[0];
         tag_d[0]   = in_tag;
         for (int k = 1; k < KEY_BYTES; k++) begin
            valid_d[k] = valid_q[k-1];
            hash_d[k]  = mix_hash[k];
            tag_d[k]   = tag_q[k-1];
         end
         valid_d[FIN] = valid_q[FIN-1];
         hash_d[FIN]  = fin_c;
         tag_d[FIN]   = tag_q[FIN-1];
      end
   end

   // Stage registers; reset drops every in-flight key.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int k = 0; k < NSTG; k++) begin
            hash_q[k] <= '0;
            tag_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < NSTG; k++) begin
            hash_q[k] <= hash_d[k];
            tag_q[k]  <= tag_d[k];
         end
      end
   end

endmodule
